// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: shares the single dcache request port between the
// load FUs and the store-queue drain path. Loads win by default with
// round-robin among load requesters; a valid store wins when it has been
// starved STARVE_MAX times, when the SQ is almost full, or when no load is
// eligible. The winner is captured into a one-entry output register that
// is held until dcache_accept.
// Optional: define DCACHE_ARB_PERF_EN to add issue/stall perf counters.
module dcache_port_arbiter #(
  parameter int unsigned NUM_LD     = 2,
  parameter int unsigned STARVE_MAX = 4
`ifdef DCACHE_ARB_PERF_EN
  , parameter int unsigned CNT_W    = 32
`endif
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic [NUM_LD-1:0]                            ld_req_valid,
  input  logic [NUM_LD-1:0][31:0]                      ld_req_addr,
  input  logic [NUM_LD-1:0][2:0]                       ld_req_func,
  output logic [NUM_LD-1:0]                            ld_grant,
  input  logic                                         st_req_valid,
  input  logic [31:0]                                  st_req_addr,
  input  logic [2:0]                                   st_req_func,
  input  logic [31:0]                                  st_req_data,
  output logic                                         st_grant,
  input  logic                                         sq_almost_full,
  input  logic                                         flush,
  output logic                                         dcache_req_valid,
  output logic                                         dcache_req_is_store,
  output logic [31:0]                                  dcache_req_addr,
  output logic [2:0]                                   dcache_req_func,
  output logic [31:0]                                  dcache_req_data,
  output logic [((NUM_LD > 1) ? $clog2(NUM_LD) : 1)-1:0] dcache_req_src,
  input  logic                                         dcache_accept
`ifdef DCACHE_ARB_PERF_EN
  , output logic [CNT_W-1:0]                           ld_issue_cnt,
  output logic [CNT_W-1:0]                             st_issue_cnt,
  output logic [CNT_W-1:0]                             stall_cnt
`endif
);

  localparam int unsigned SRC_W = (NUM_LD > 1) ? $clog2(NUM_LD) : 1;
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

  // Output register
  logic              r_valid;
  logic              r_is_store;
  logic [31:0]       r_addr;
  logic [2:0]        r_func;
  logic [31:0]       r_data;
  logic [SRC_W-1:0]  r_src;

  // Arbitration state
  logic [SRC_W-1:0]  r_rr;
  logic [STV_W-1:0]  r_starve;

  // Combinational arbitration results
  logic [NUM_LD-1:0] w_ld_elig;
  logic              w_can_capture;
  logic              w_store_prio;
  logic              w_ld_found;
  logic [SRC_W-1:0]  w_ld_sel;
  logic              w_ld_any;
  logic              w_st_grant;
  logic [NUM_LD-1:0] w_ld_grant;

  // Grant selection: store priority check, then round-robin search from r_rr
  always_comb begin
    logic [SRC_W-1:0] v_idx;
    w_ld_elig     = flush ? '0 : ld_req_valid;
    // A held load that is being flushed frees the register this cycle, so
    // a store can be captured in its place without waiting for accept.
    w_can_capture = !r_valid || dcache_accept || (flush && !r_is_store);
    w_store_prio  = st_req_valid &&
                    ((r_starve == STV_W'(STARVE_MAX)) || sq_almost_full || (w_ld_elig == '0));
    w_ld_found    = 1'b0;
    w_ld_sel      = '0;
    v_idx         = '0;
    for (int unsigned k = 0; k < NUM_LD; k++) begin
      v_idx = SRC_W'((32'(r_rr) + k) % NUM_LD);
      if (!w_ld_found && w_ld_elig[v_idx]) begin
        w_ld_found = 1'b1;
        w_ld_sel   = v_idx;
      end
    end
    w_st_grant = w_can_capture && w_store_prio;
    w_ld_any   = w_can_capture && !w_store_prio && w_ld_found;
    w_ld_grant = '0;
    if (w_ld_any) w_ld_grant[w_ld_sel] = 1'b1;
  end

  assign ld_grant = w_ld_grant;
  assign st_grant = w_st_grant;

  // Output register: capture winner, drop on accept or on flush of a held load
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_is_store <= 1'b0;
      r_addr     <= '0;
      r_func     <= '0;
      r_data     <= '0;
      r_src      <= '0;
    end else if (w_st_grant) begin
      r_valid    <= 1'b1;
      r_is_store <= 1'b1;
      r_addr     <= st_req_addr;
      r_func     <= st_req_func;
      r_data     <= st_req_data;
      r_src      <= '0;
    end else if (w_ld_any) begin
      r_valid    <= 1'b1;
      r_is_store <= 1'b0;
      r_addr     <= ld_req_addr[w_ld_sel];
      r_func     <= ld_req_func[w_ld_sel];
      r_data     <= '0;
      r_src      <= w_ld_sel;
    end else if (r_valid && (dcache_accept || (flush && !r_is_store))) begin
      r_valid    <= 1'b0;
    end
  end

  // Round-robin pointer and store starvation counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr     <= '0;
      r_starve <= '0;
    end else begin
      if (w_ld_any)
        r_rr <= (w_ld_sel == SRC_W'(NUM_LD - 1)) ? '0 : w_ld_sel + 1'b1;
      if (w_st_grant)
        r_starve <= '0;
      else if (st_req_valid && w_ld_any && (r_starve != STV_W'(STARVE_MAX)))
        r_starve <= r_starve + 1'b1;
    end
  end

  assign dcache_req_valid    = r_valid;
  assign dcache_req_is_store = r_is_store;
  assign dcache_req_addr     = r_addr;
  assign dcache_req_func     = r_func;
  assign dcache_req_data     = r_data;
  assign dcache_req_src      = r_src;

`ifdef DCACHE_ARB_PERF_EN
  logic [CNT_W-1:0] r_ld_cnt;
  logic [CNT_W-1:0] r_st_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  // Saturating perf counters for accepted loads/stores and stalled cycles
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ld_cnt    <= '0;
      r_st_cnt    <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (r_valid && dcache_accept && !r_is_store && (r_ld_cnt != '1))
        r_ld_cnt <= r_ld_cnt + 1'b1;
      if (r_valid && dcache_accept && r_is_store && (r_st_cnt != '1))
        r_st_cnt <= r_st_cnt + 1'b1;
      if (r_valid && !dcache_accept && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign ld_issue_cnt = r_ld_cnt;
  assign st_issue_cnt = r_st_cnt;
  assign stall_cnt    = r_stall_cnt;
`endif

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed testbench for dcache_port_arbiter: a table of per-cycle vectors
// run from reset, followed by a hand-written reset/backpressure sequence.
// Define DCACHE_ARB_PERF_EN to include the perf-counter checks.
module tb_dcache_port_arbiter;

  logic             clock;
  logic             reset;
  logic [1:0]       ld_req_valid;
  logic [1:0][31:0] ld_req_addr;
  logic [1:0][2:0]  ld_req_func;
  logic [1:0]       ld_grant;
  logic             st_req_valid;
  logic [31:0]      st_req_addr;
  logic [2:0]       st_req_func;
  logic [31:0]      st_req_data;
  logic             st_grant;
  logic             sq_almost_full;
  logic             flush;
  logic             dcache_req_valid;
  logic             dcache_req_is_store;
  logic [31:0]      dcache_req_addr;
  logic [2:0]       dcache_req_func;
  logic [31:0]      dcache_req_data;
  logic [0:0]       dcache_req_src;
  logic             dcache_accept;
`ifdef DCACHE_ARB_PERF_EN
  logic [31:0]      ld_issue_cnt;
  logic [31:0]      st_issue_cnt;
  logic [31:0]      stall_cnt;
`endif

  dcache_port_arbiter #(.NUM_LD(2), .STARVE_MAX(4)) dut (
    .clock               (clock),
    .reset               (reset),
    .ld_req_valid        (ld_req_valid),
    .ld_req_addr         (ld_req_addr),
    .ld_req_func         (ld_req_func),
    .ld_grant            (ld_grant),
    .st_req_valid        (st_req_valid),
    .st_req_addr         (st_req_addr),
    .st_req_func         (st_req_func),
    .st_req_data         (st_req_data),
    .st_grant            (st_grant),
    .sq_almost_full      (sq_almost_full),
    .flush               (flush),
    .dcache_req_valid    (dcache_req_valid),
    .dcache_req_is_store (dcache_req_is_store),
    .dcache_req_addr     (dcache_req_addr),
    .dcache_req_func     (dcache_req_func),
    .dcache_req_data     (dcache_req_data),
    .dcache_req_src      (dcache_req_src),
    .dcache_accept       (dcache_accept)
`ifdef DCACHE_ARB_PERF_EN
    , .ld_issue_cnt      (ld_issue_cnt),
    .st_issue_cnt        (st_issue_cnt),
    .stall_cnt           (stall_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Fixed request payloads: load0, load1, store
  function automatic logic [31:0] e_addr(input logic is_st, input logic src);
    return is_st ? 32'h0000_0300 : (src ? 32'h0000_0200 : 32'h0000_0100);
  endfunction
  function automatic logic [31:0] e_data(input logic is_st);
    return is_st ? 32'hDEAD_BEEF : 32'h0;
  endfunction
  function automatic logic [2:0] e_func(input logic is_st, input logic src);
    return is_st ? 3'd1 : (src ? 3'd4 : 3'd2);
  endfunction

  typedef struct {
    logic [1:0] ldv;
    logic       stv, af, fl, acc;
    logic [1:0] eldg;
    logic       estg, ev, est, esrc;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] ldv, input logic stv, input logic af,
                              input logic fl, input logic acc, input logic [1:0] eldg,
                              input logic estg, input logic ev, input logic est,
                              input logic esrc);
    vec_t v;
    v.ldv = ldv; v.stv = stv; v.af = af; v.fl = fl; v.acc = acc;
    v.eldg = eldg; v.estg = estg; v.ev = ev; v.est = est; v.esrc = esrc;
    return v;
  endfunction

  task automatic drive(input logic [1:0] ldv, input logic stv, input logic af,
                       input logic fl, input logic acc);
    ld_req_valid   = ldv;
    st_req_valid   = stv;
    sq_almost_full = af;
    flush          = fl;
    dcache_accept  = acc;
  endtask

  task automatic chk_reg(input string tag, input logic ev, input logic est, input logic esrc);
    chk({tag, " valid"}, 32'(dcache_req_valid), 32'(ev));
    if (ev) begin
      chk({tag, " is_store"}, 32'(dcache_req_is_store), 32'(est));
      chk({tag, " addr"}, dcache_req_addr, e_addr(est, esrc));
      chk({tag, " data"}, dcache_req_data, e_data(est));
      chk({tag, " func"}, 32'(dcache_req_func), 32'(e_func(est, esrc)));
      chk({tag, " src"}, 32'(dcache_req_src), est ? 32'd0 : 32'(esrc));
    end
  endtask

  vec_t tbl[30];

  initial begin
    // ldv, stv, af, fl, acc | eldg, estg, ev, est, esrc
    tbl[0]  = mk(2'b01, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0); // single load
    tbl[1]  = mk(2'b00, 0, 0, 0, 1, 2'b00, 0, 1, 0, 0);
    tbl[2]  = mk(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    tbl[3]  = mk(2'b11, 0, 0, 0, 1, 2'b10, 0, 0, 0, 0); // round-robin
    tbl[4]  = mk(2'b11, 0, 0, 0, 1, 2'b01, 0, 1, 0, 1);
    tbl[5]  = mk(2'b11, 0, 0, 0, 1, 2'b10, 0, 1, 0, 0);
    tbl[6]  = mk(2'b11, 0, 0, 0, 1, 2'b01, 0, 1, 0, 1);
    tbl[7]  = mk(2'b11, 1, 0, 0, 1, 2'b10, 0, 1, 0, 0); // starvation
    tbl[8]  = mk(2'b11, 1, 0, 0, 1, 2'b01, 0, 1, 0, 1);
    tbl[9]  = mk(2'b11, 1, 0, 0, 1, 2'b10, 0, 1, 0, 0);
    tbl[10] = mk(2'b11, 1, 0, 0, 1, 2'b01, 0, 1, 0, 1);
    tbl[11] = mk(2'b11, 1, 0, 0, 1, 2'b00, 1, 1, 0, 0);
    tbl[12] = mk(2'b11, 1, 0, 0, 1, 2'b10, 0, 1, 1, 0); // counter cleared
    tbl[13] = mk(2'b00, 0, 0, 0, 1, 2'b00, 0, 1, 0, 1);
    tbl[14] = mk(2'b01, 1, 1, 0, 0, 2'b00, 1, 0, 0, 0); // sq_almost_full
    tbl[15] = mk(2'b01, 0, 0, 0, 0, 2'b00, 0, 1, 1, 0); // stalled: no grant
    tbl[16] = mk(2'b01, 0, 0, 0, 1, 2'b01, 0, 1, 1, 0);
    tbl[17] = mk(2'b10, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0); // backpressure
    tbl[18] = mk(2'b10, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0);
    tbl[19] = mk(2'b10, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0);
    tbl[20] = mk(2'b10, 0, 0, 0, 1, 2'b10, 0, 1, 0, 0);
    tbl[21] = mk(2'b01, 0, 0, 0, 0, 2'b00, 0, 1, 0, 1);
    tbl[22] = mk(2'b01, 1, 0, 1, 0, 2'b00, 1, 1, 0, 1); // flush replaces load
    tbl[23] = mk(2'b00, 0, 0, 0, 0, 2'b00, 0, 1, 1, 0);
    tbl[24] = mk(2'b01, 0, 0, 1, 0, 2'b00, 0, 1, 1, 0); // store survives flush
    tbl[25] = mk(2'b00, 0, 0, 0, 1, 2'b00, 0, 1, 1, 0);
    tbl[26] = mk(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    tbl[27] = mk(2'b10, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0);
    tbl[28] = mk(2'b01, 0, 0, 1, 0, 2'b00, 0, 1, 0, 1); // flush drops load
    tbl[29] = mk(2'b01, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0);

    ld_req_addr = {32'h0000_0200, 32'h0000_0100};
    ld_req_func = {3'd4, 3'd2};
    st_req_addr = 32'h0000_0300;
    st_req_func = 3'd1;
    st_req_data = 32'hDEAD_BEEF;
    drive(2'b00, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("reset grant", {30'd0, ld_grant}, 32'd0);
    chk("reset st_grant", 32'(st_grant), 32'd0);
    chk("reset valid", 32'(dcache_req_valid), 32'd0);
    chk("reset addr", dcache_req_addr, 32'd0);
    chk("reset data", dcache_req_data, 32'd0);
    chk("reset is_store", 32'(dcache_req_is_store), 32'd0);

    for (int i = 0; i < 30; i++) begin
      if (i != 0) @(negedge clock);
      drive(tbl[i].ldv, tbl[i].stv, tbl[i].af, tbl[i].fl, tbl[i].acc);
      #1;
      chk($sformatf("s%0d ld_grant", i), 32'(ld_grant), 32'(tbl[i].eldg));
      chk($sformatf("s%0d st_grant", i), 32'(st_grant), 32'(tbl[i].estg));
      chk_reg($sformatf("s%0d", i), tbl[i].ev, tbl[i].est, tbl[i].esrc);
    end

    // Mid-run reset: pointer had advanced to 1, must return to 0
    @(negedge clock);
    drive(2'b00, 0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst2 valid", 32'(dcache_req_valid), 32'd0);
`ifdef DCACHE_ARB_PERF_EN
    chk("rst2 ld_cnt", ld_issue_cnt, 32'd0);
    chk("rst2 st_cnt", st_issue_cnt, 32'd0);
    chk("rst2 stall_cnt", stall_cnt, 32'd0);
`endif
    drive(2'b11, 0, 0, 0, 0);
    #1;
    chk("rst2 rr grant", 32'(ld_grant), 32'd1);

    // Hold the captured load for three stalled cycles
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      drive(2'b10, 0, 0, 0, 0);
      #1;
      chk($sformatf("bp%0d ld_grant", c), 32'(ld_grant), 32'd0);
      chk_reg($sformatf("bp%0d", c), 1'b1, 1'b0, 1'b0);
    end
    @(negedge clock);
    drive(2'b10, 0, 0, 0, 1);
    #1;
    chk("bp resume grant", 32'(ld_grant), 32'd2);
`ifdef DCACHE_ARB_PERF_EN
    chk("bp stall_cnt", stall_cnt, 32'd3);
    chk("bp ld_cnt before", ld_issue_cnt, 32'd0);
`endif
    @(negedge clock);
    drive(2'b00, 0, 0, 0, 1);
    #1;
    chk_reg("bp next", 1'b1, 1'b0, 1'b1);
`ifdef DCACHE_ARB_PERF_EN
    chk("bp ld_cnt after", ld_issue_cnt, 32'd1);
    chk("bp st_cnt", st_issue_cnt, 32'd0);
    chk("bp stall_cnt hold", stall_cnt, 32'd3);
`endif
    @(negedge clock);
    drive(2'b00, 0, 0, 0, 0);
    #1;
    chk("bp drained valid", 32'(dcache_req_valid), 32'd0);
`ifdef DCACHE_ARB_PERF_EN
    chk("bp ld_cnt final", ld_issue_cnt, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
